// File: rtl/cube_buffer_write_arbiter_if.sv
// Bundles the two producer ports and the shared frame-buffer write port.
// "slave" is the arbiter's view of the bundle.
// "master" is the producer/frame-buffer side of the bundle.
interface cube_buffer_write_arbiter_if;
  logic        usb_req;
  logic [31:0] usb_chunk_data;
  logic [3:0]  usb_chunk_addr;
  logic [3:0]  usb_row_addr;
  logic [1:0]  usb_panel_addr;
  logic        usb_chunk_write_enable;
  logic        usb_grant;
  logic        pat_req;
  logic [31:0] pat_chunk_data;
  logic [3:0]  pat_chunk_addr;
  logic [3:0]  pat_row_addr;
  logic [1:0]  pat_panel_addr;
  logic        pat_chunk_write_enable;
  logic        pat_grant;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        chunk_write_enable;
  logic [1:0]  owner;
  logic        row_done;
  logic [7:0]  timeout_count;

  modport slave (
    input  usb_req, usb_chunk_data, usb_chunk_addr, usb_row_addr, usb_panel_addr,
           usb_chunk_write_enable,
    input  pat_req, pat_chunk_data, pat_chunk_addr, pat_row_addr, pat_panel_addr,
           pat_chunk_write_enable,
    output usb_grant, pat_grant, chunk_data, chunk_addr, row_addr, panel_addr,
           chunk_write_enable, owner, row_done, timeout_count
  );

  modport master (
    output usb_req, usb_chunk_data, usb_chunk_addr, usb_row_addr, usb_panel_addr,
           usb_chunk_write_enable,
    output pat_req, pat_chunk_data, pat_chunk_addr, pat_row_addr, pat_panel_addr,
           pat_chunk_write_enable,
    input  usb_grant, pat_grant, chunk_data, chunk_addr, row_addr, panel_addr,
           chunk_write_enable, owner, row_done, timeout_count
  );
endinterface

// File: rtl/cube_buffer_write_arbiter.sv
// Row-atomic arbiter sharing the frame-buffer write port between the USB
// host path and the on-board pattern generator. All outputs are registered.
// The owner's write appears on the bus one cycle after it is presented.
module cube_buffer_write_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CHUNKS_PER_ROW = 16,
  parameter int USB_PRIORITY   = 1
) (
  input logic                         clk,
  input logic                         reset,
  cube_buffer_write_arbiter_if.slave  bus
);

  localparam int              WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_CHUNK = 4'(CHUNKS_PER_ROW - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_USB = 2'd1,
    ST_GRANT_PAT = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  state_t          state_r, state_next_s;
  logic [WD_W-1:0] wdog_r;
  logic            usb_next_r;
  logic            usb_grant_r, pat_grant_r, cwe_r, row_done_r;
  logic [1:0]      owner_r;
  logic [31:0]     data_r;
  logic [3:0]      chunk_addr_r, row_addr_r;
  logic [1:0]      panel_addr_r;
  logic [7:0]      timeout_count_r;

  logic            owner_req_s, owner_we_s, row_end_s, timeout_s;
  logic [31:0]     owner_data_s;
  logic [3:0]      owner_chunk_s, owner_row_s;
  logic [1:0]      owner_panel_s;

  // Select the current owner's request and write bus; nothing is selected outside a grant.
  always_comb begin
    owner_req_s   = 1'b0;
    owner_we_s    = 1'b0;
    owner_data_s  = 32'h0000_0000;
    owner_chunk_s = 4'h0;
    owner_row_s   = 4'h0;
    owner_panel_s = 2'h0;
    case (state_r)
      ST_GRANT_USB: begin
        owner_req_s   = bus.usb_req;
        owner_we_s    = bus.usb_chunk_write_enable;
        owner_data_s  = bus.usb_chunk_data;
        owner_chunk_s = bus.usb_chunk_addr;
        owner_row_s   = bus.usb_row_addr;
        owner_panel_s = bus.usb_panel_addr;
      end
      ST_GRANT_PAT: begin
        owner_req_s   = bus.pat_req;
        owner_we_s    = bus.pat_chunk_write_enable;
        owner_data_s  = bus.pat_chunk_data;
        owner_chunk_s = bus.pat_chunk_addr;
        owner_row_s   = bus.pat_row_addr;
        owner_panel_s = bus.pat_panel_addr;
      end
      default: begin
        owner_req_s = 1'b0;
        owner_we_s  = 1'b0;
      end
    endcase
  end

  // Next-state decision; in a grant, row completion beats request drop, which beats the watchdog.
  always_comb begin
    state_next_s = state_r;
    row_end_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.usb_req && bus.pat_req) begin
          if ((USB_PRIORITY != 0) || usb_next_r) begin
            state_next_s = ST_GRANT_USB;
          end else begin
            state_next_s = ST_GRANT_PAT;
          end
        end else if (bus.usb_req) begin
          state_next_s = ST_GRANT_USB;
        end else if (bus.pat_req) begin
          state_next_s = ST_GRANT_PAT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GRANT_USB, ST_GRANT_PAT: begin
        if (owner_we_s && (owner_chunk_s == LAST_CHUNK)) begin
          state_next_s = ST_RELEASE;
          row_end_s    = 1'b1;
        end else if (!owner_req_s) begin
          state_next_s = ST_RELEASE;
        end else if (!owner_we_s && (wdog_r == WD_LAST)) begin
          state_next_s = ST_RELEASE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RELEASE: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // State register, watchdog and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wdog_r     <= '0;
      usb_next_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_GRANT_USB) || (state_r == ST_GRANT_PAT)) begin
        wdog_r <= owner_we_s ? '0 : (wdog_r + WD_W'(1));
      end else begin
        wdog_r <= '0;
      end
      if ((state_r == ST_IDLE) && (state_next_s == ST_GRANT_USB)) begin
        usb_next_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && (state_next_s == ST_GRANT_PAT)) begin
        usb_next_r <= 1'b1;
      end
    end
  end

  // Registered grant/owner flags, forwarded write bus, row-done pulse and revocation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      usb_grant_r     <= 1'b0;
      pat_grant_r     <= 1'b0;
      owner_r         <= 2'b00;
      cwe_r           <= 1'b0;
      row_done_r      <= 1'b0;
      data_r          <= 32'h0000_0000;
      chunk_addr_r    <= 4'h0;
      row_addr_r      <= 4'h0;
      panel_addr_r    <= 2'h0;
      timeout_count_r <= 8'h00;
    end else begin
      usb_grant_r <= (state_next_s == ST_GRANT_USB);
      pat_grant_r <= (state_next_s == ST_GRANT_PAT);
      owner_r     <= {(state_next_s == ST_GRANT_PAT), (state_next_s == ST_GRANT_USB)};
      cwe_r       <= owner_we_s;
      row_done_r  <= row_end_s;
      if (owner_we_s) begin
        data_r       <= owner_data_s;
        chunk_addr_r <= owner_chunk_s;
        row_addr_r   <= owner_row_s;
        panel_addr_r <= owner_panel_s;
      end
      if (timeout_s && (timeout_count_r != 8'hFF)) begin
        timeout_count_r <= timeout_count_r + 8'd1;
      end
    end
  end

  assign bus.usb_grant          = usb_grant_r;
  assign bus.pat_grant          = pat_grant_r;
  assign bus.owner              = owner_r;
  assign bus.chunk_write_enable = cwe_r;
  assign bus.row_done           = row_done_r;
  assign bus.chunk_data         = data_r;
  assign bus.chunk_addr         = chunk_addr_r;
  assign bus.row_addr           = row_addr_r;
  assign bus.panel_addr         = panel_addr_r;
  assign bus.timeout_count      = timeout_count_r;

endmodule

// File: doc/cube_buffer_write_arbiter.md
Name: cube_buffer_write_arbiter

Overview:
- Shares the single frame-buffer write port (chunk_data/chunk_addr/row_addr/panel_addr/chunk_write_enable) between two requesters:
  - the USB host path (usb_controller);
  - the on-board pattern generator (standalone demo mode).
- Grants are row-atomic: once granted, a requester owns the port until it completes a 16-chunk row, drops its request, or stalls past a watchdog limit.
- Sits between both producers and the frame buffer. All outputs are registered.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles without a write, while granted, before the grant is forcibly revoked.
- CHUNKS_PER_ROW, 16: chunk index CHUNKS_PER_ROW-1 marks the end of a row.
- USB_PRIORITY, 1: 1 = USB wins simultaneous requests; 0 = round-robin.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- usb_req  in  1  USB path requests the port
- usb_chunk_data  in  32  USB write data
- usb_chunk_addr  in  4  USB chunk index within the row
- usb_row_addr  in  4  USB row
- usb_panel_addr  in  2  USB panel
- usb_chunk_write_enable  in  1  USB write strobe
- usb_grant  out  1  USB owns the port
- pat_req  in  1  pattern generator requests the port
- pat_chunk_data  in  32  pattern write data
- pat_chunk_addr  in  4  pattern chunk index
- pat_row_addr  in  4  pattern row
- pat_panel_addr  in  2  pattern panel
- pat_chunk_write_enable  in  1  pattern write strobe
- pat_grant  out  1  pattern generator owns the port
- chunk_data  out  32  to frame buffer
- chunk_addr  out  4  to frame buffer
- row_addr  out  4  to frame buffer
- panel_addr  out  2  to frame buffer
- chunk_write_enable  out  1  to frame buffer
- owner  out  2  00 none, 01 USB, 10 pattern
- row_done  out  1  one-cycle pulse on row completion
- timeout_count  out  8  saturating count of watchdog revocations

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - all outputs 0; owner=00;
  - state IDLE; watchdog=0; round-robin pointer = USB next.
- States:
  - IDLE:
    - no req: stay.
    - only one req: go to that requester's GRANT state.
    - both req, USB_PRIORITY=1: GRANT_USB.
    - both req, USB_PRIORITY=0: grant the requester not served last; pointer updates on each grant.
  - GRANT_USB / GRANT_PAT:
    - grant output and owner are high for the whole state, starting the cycle after the transition.
    - The first grant cycle is the earliest cycle whose write is accepted.
  - RELEASE: exactly 1 cycle with grants low, then IDLE. Guarantees a 2-cycle minimum gap between owners; no back-to-back grant even when the same requester re-requests.
- Write path:
  - In a GRANT state, the owner's write strobe, data and addresses are registered onto the output bus.
  - Latency: exactly 1 cycle.
  - Non-owner strobes are dropped silently, never queued.
  - chunk_write_enable is 0 in IDLE and RELEASE.
  - Data/address outputs hold their last value when not writing.
- Exit from GRANT to RELEASE, priority order:
  - Owner writes with chunk_addr==CHUNKS_PER_ROW-1: that write is forwarded normally; row_done pulses the same cycle it appears on the output.
  - Owner req low: exit in the same evaluation cycle; any strobe presented that cycle is still forwarded.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no write: timeout_count increments, saturating at 255.
- Watchdog:
  - cleared on entry to GRANT and on every owner write;
  - otherwise increments each GRANT cycle;
  - width is clog2(TIMEOUT_CYCLES).
- Simultaneous events:
  - final-chunk write in the same cycle as req drop counts as row completion (row_done=1), not as abandonment.
  - A write on the watchdog's last cycle clears it; no timeout.
- Reset mid-grant: next cycle all outputs 0 and state IDLE. The in-flight write is dropped, row_done is not pulsed, and timeout_count is cleared.
- Addresses are forwarded unmodified. The block does not check chunk ordering or row consistency.

Test Plan:
- Reset 5 cycles, then usb_req=1 only → usb_grant=1 and owner=01 from 2nd cycle after reset release; pat_grant=0.
- USB writes chunks 0..15 (data 32'h00000000..32'h0000000F, row 4'h3, panel 2'h1) → each appears 1 cycle later; row_done pulses with chunk 15; usb_grant low for RELEASE cycle.
- usb_req and pat_req rise same cycle, USB_PRIORITY=1 → USB granted. Pattern strobes during USB grant produce no output writes. After USB row completes, pat_grant rises after RELEASE+IDLE.
- USB_PRIORITY=0, both requesting continuously, each finishing rows → grants alternate USB, PAT, USB, PAT.
- Grant USB, then no writes for 1024 cycles (req held) → grant revoked, timeout_count=1. Repeat 300 times → timeout_count stays 255.
- Assert reset during USB chunk 7 write → next cycle chunk_write_enable=0, owner=00, timeout_count=0, no row_done.
